// File: rtl/trng_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : trng_word_packer
// Purpose  : Packs debiased TRNG bits MSB-first into WORD_W-bit words, runs a
//            repetition-count health test on the bit stream and buffers
//            completed words in a small FIFO with a valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module trng_word_packer #(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int REP_LIMIT  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          bit_valid,
    input  logic                          bit_in,
    input  logic                          clear,
    output logic                          word_valid,
    output logic [WORD_W-1:0]             word_data,
    input  logic                          word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic [$clog2(WORD_W)-1:0]     bit_count,
    output logic                          overflow,
    output logic                          health_fail
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int RUN_W = $clog2(REP_LIMIT + 1);

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic                last_q, last_d;
    logic                ovf_q, ovf_d;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]      fill_q, fill_d;
    logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];

    logic [WORD_W-1:0]   push_word;
    logic [RUN_W-1:0]    run_next;
    logic                push;
    logic                pop;
    logic                full;
    logic                push_ok;

    // Word assembly, repetition-count test and FILL/FAULT transitions.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        run_d     = run_q;
        last_d    = last_q;
        push      = 1'b0;
        push_word = {shift_q[WORD_W-2:0], bit_in};
        // A zero run counter means no bit has been seen since reset/clear.
        run_next  = ((run_q != '0) && (bit_in == last_q)) ? run_q + RUN_W'(1) : RUN_W'(1);
        if (clear) begin
            state_d = ST_FILL;
            shift_d = '0;
            cnt_d   = '0;
            run_d   = '0;
            last_d  = 1'b0;
        end else if ((state_q == ST_FILL) && bit_valid) begin
            run_d  = run_next;
            last_d = bit_in;
            if (run_next == RUN_W'(REP_LIMIT)) begin
                // Tripping bit is never packed and the partial word is dropped.
                state_d = ST_FAULT;
                shift_d = '0;
                cnt_d   = '0;
            end else begin
                shift_d = push_word;
                if (cnt_q == CNT_W'(WORD_W - 1)) begin
                    cnt_d = '0;
                    push  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // FIFO bookkeeping: a simultaneous pop frees a slot for a push when full.
    always_comb begin
        pop     = word_valid && word_ready;
        full    = (fill_q == (PTR_W+1)'(FIFO_DEPTH));
        push_ok = push && (!full || pop);
        fill_d  = fill_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
        ovf_d   = ovf_q;
        if (clear) begin
            ovf_d = 1'b0;
        end else if (push && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    // Control and datapath state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_FILL;
            shift_q  <= '0;
            cnt_q    <= '0;
            run_q    <= '0;
            last_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
            fill_q   <= fill_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // FIFO storage; contents are only observable through the valid head.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign word_valid  = (fill_q != '0);
    assign word_data   = word_valid ? mem_q[rd_ptr_q] : '0;
    assign fill_level  = fill_q;
    assign bit_count   = cnt_q;
    assign overflow    = ovf_q;
    assign health_fail = (state_q == ST_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_trng_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_trng_word_packer
// Purpose  : Self-checking bench for trng_word_packer. Two instances share
//            stimulus: A uses REP_LIMIT=4, B uses REP_LIMIT=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trng_word_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic r_reset = 1'b1;
    logic r_bv    = 1'b0;
    logic r_bit   = 1'b0;
    logic r_clr   = 1'b0;
    logic r_rdy   = 1'b0;

    logic       a_wv, b_wv;
    logic [7:0] a_wd, b_wd;
    logic [2:0] a_fill, b_fill, a_bc, b_bc;
    logic       a_ovf, b_ovf, a_hf, b_hf;

    trng_word_packer #(.WORD_W(8), .FIFO_DEPTH(4), .REP_LIMIT(4)) dut_a (
        .clk(clk), .reset(r_reset), .bit_valid(r_bv), .bit_in(r_bit), .clear(r_clr),
        .word_valid(a_wv), .word_data(a_wd), .word_ready(r_rdy), .fill_level(a_fill),
        .bit_count(a_bc), .overflow(a_ovf), .health_fail(a_hf)
    );

    trng_word_packer #(.WORD_W(8), .FIFO_DEPTH(4), .REP_LIMIT(8)) dut_b (
        .clk(clk), .reset(r_reset), .bit_valid(r_bv), .bit_in(r_bit), .clear(r_clr),
        .word_valid(b_wv), .word_data(b_wd), .word_ready(r_rdy), .fill_level(b_fill),
        .bit_count(b_bc), .overflow(b_ovf), .health_fail(b_hf)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: partial word as an integer, FIFO as an ordered list.
    int m_val  [2];
    int m_n    [2];
    int m_run  [2];
    int m_last [2];
    bit m_fault[2];
    bit m_ovf  [2];
    int mq     [2][0:7];
    int msz    [2];
    int lim    [2] = '{4, 8};

    task automatic model_update(input int k);
        bit pop;
        bit do_push;
        int w;
        do_push = 1'b0;
        w = 0;
        if (r_reset) begin
            m_val[k] = 0; m_n[k] = 0; m_run[k] = 0; m_last[k] = 0;
            m_fault[k] = 1'b0; m_ovf[k] = 1'b0; msz[k] = 0;
            return;
        end
        pop = (msz[k] > 0) && r_rdy;
        if (r_clr) begin
            m_val[k] = 0; m_n[k] = 0; m_run[k] = 0;
            m_fault[k] = 1'b0; m_ovf[k] = 1'b0;
        end else if (!m_fault[k] && r_bv) begin
            m_run[k]  = (m_run[k] > 0 && int'(r_bit) == m_last[k]) ? m_run[k] + 1 : 1;
            m_last[k] = int'(r_bit);
            if (m_run[k] >= lim[k]) begin
                m_fault[k] = 1'b1; m_n[k] = 0; m_val[k] = 0;
            end else begin
                m_val[k] = m_val[k] * 2 + int'(r_bit);
                m_n[k]++;
                if (m_n[k] == 8) begin
                    w = m_val[k] % 256; do_push = 1'b1; m_n[k] = 0; m_val[k] = 0;
                end
            end
        end
        if (pop) begin
            for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
            msz[k]--;
        end
        if (do_push) begin
            if (msz[k] < 4) begin
                mq[k][msz[k]] = w; msz[k]++;
            end else begin
                m_ovf[k] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("word_valid_%0d", k), 32'(k == 0 ? a_wv : b_wv), 32'(msz[k] > 0));
            chk($sformatf("fill_level_%0d", k), 32'(k == 0 ? a_fill : b_fill), 32'(msz[k]));
            chk($sformatf("bit_count_%0d", k), 32'(k == 0 ? a_bc : b_bc), 32'(m_n[k]));
            chk($sformatf("overflow_%0d", k), 32'(k == 0 ? a_ovf : b_ovf), 32'(m_ovf[k]));
            chk($sformatf("health_fail_%0d", k), 32'(k == 0 ? a_hf : b_hf), 32'(m_fault[k]));
            if (msz[k] > 0)
                chk($sformatf("word_data_%0d", k), 32'(k == 0 ? a_wd : b_wd), 32'(mq[k][0]));
        end
    endtask

    task automatic cyc(input bit bv, input bit b, input bit clr, input bit rdy);
        r_bv = bv; r_bit = b; r_clr = clr; r_rdy = rdy;
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        r_reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        r_reset = 1'b0;
    endtask

    // Feeds one byte MSB-first; optional idle gap after each bit.
    task automatic send_byte(input logic [7:0] v, input bit gap, input bit rdy);
        logic [7:0] t;
        t = v;
        for (int i = 7; i >= 0; i--) begin
            cyc(1'b1, t[i], 1'b0, rdy);
            if (gap) cyc(1'b0, 1'b0, 1'b0, rdy);
        end
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] exp_order [4];

        // Reset state.
        do_reset();
        chk("rst_a_data", 32'(a_wd), 32'h0);
        chk("rst_a_valid", 32'(a_wv), 32'h0);

        // 1. Basic packing, one-cycle visibility with ready held high.
        pat = 8'hB2;
        for (int i = 7; i >= 0; i--) cyc(1'b1, pat[i], 1'b0, 1'b1);
        chk("t1_valid", 32'(a_wv), 32'h1);
        chk("t1_data", 32'(a_wd), 32'hB2);
        chk("t1_bitcnt", 32'(a_bc), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_popped", 32'(a_wv), 32'h0);

        // 2. Gapped input with backpressure (checked on the REP_LIMIT=8 unit).
        do_reset();
        send_byte(8'h5A, 1'b1, 1'b0);
        send_byte(8'hC3, 1'b1, 1'b0);
        chk("t2_fill", 32'(b_fill), 32'h2);
        chk("t2_head", 32'(b_wd), 32'h5A);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_stable", 32'(b_wd), 32'h5A);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t2_second", 32'(b_wd), 32'hC3);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t2_empty", 32'(b_fill), 32'h0);

        // 3. Overflow, then push and pop together while full.
        do_reset();
        for (int w = 1; w <= 5; w++) send_byte(8'(w), 1'b0, 1'b0);
        chk("t3_fill", 32'(b_fill), 32'h4);
        chk("t3_ovf", 32'(b_ovf), 32'h1);
        pat = 8'h06;
        for (int i = 7; i >= 0; i--) cyc(1'b1, pat[i], 1'b0, (i == 0));
        chk("t3_fill_kept", 32'(b_fill), 32'h4);
        exp_order = '{8'h02, 8'h03, 8'h04, 8'h06};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_order%0d", i), 32'(b_wd), 32'(exp_order[i]));
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("t3_drained", 32'(b_wv), 32'h0);

        // 4. Health trip on four identical bits, then recovery by clear.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t4_hf", 32'(a_hf), 32'h1);
        chk("t4_bitcnt", 32'(a_bc), 32'h0);
        chk("t4_nopush", 32'(a_fill), 32'h0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'(i), 1'b0, 1'b0);
        chk("t4_ignored", 32'(a_bc), 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_cleared", 32'(a_hf), 32'h0);
        send_byte(8'h96, 1'b0, 1'b0);
        chk("t4_data", 32'(a_wd), 32'h96);

        // 5. Clear with a coincident bit, then reset mid-stream.
        pat = 8'hA8;
        for (int i = 7; i >= 3; i--) cyc(1'b1, pat[i], 1'b0, 1'b0);
        chk("t5_partial", 32'(a_bc), 32'h5);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t5_bitcnt", 32'(a_bc), 32'h0);
        chk("t5_fifo_kept", 32'(a_fill), 32'h1);
        chk("t5_head_kept", 32'(a_wd), 32'h96);
        do_reset();
        chk("t5_rst_fill", 32'(a_fill), 32'h0);
        chk("t5_rst_valid", 32'(a_wv), 32'h0);
        chk("t5_rst_data", 32'(a_wd), 32'h0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 4000; n++) begin
            r_reset = ($urandom_range(0, 599) == 0);
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 59) == 0),
                1'($urandom_range(0, 2) == 0));
            r_reset = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
